// File: rtl/vga_sync_decoder_if.sv
// Sync-input / recovered-timing bundle for the VGA sync decoder.
// Master drives the syncs and observes the recovered timing; slave is the decoder.
interface vga_sync_decoder_if #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480
);
  localparam int unsigned XW = $clog2(H_VISIBLE);
  localparam int unsigned YW = $clog2(V_VISIBLE);

  logic          hsync_i;
  logic          vsync_i;
  logic          locked_o;
  logic          visible_o;
  logic [XW-1:0] position_x_o;
  logic [YW-1:0] position_y_o;
  logic          frame_start_o;
  logic          error_o;

  modport master (
    output hsync_i, vsync_i,
    input  locked_o, visible_o, position_x_o, position_y_o, frame_start_o, error_o
  );

  modport slave (
    input  hsync_i, vsync_i,
    output locked_o, visible_o, position_x_o, position_y_o, frame_start_o, error_o
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and lock status from bare active-low hsync/vsync,
// flagging any sync edge that disagrees with the configured timing.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vga_sync_decoder_if.slave  vga
);

  localparam int unsigned WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS0 = H_VISIBLE + H_FRONT;
  localparam int unsigned HS1 = HS0 + H_SYNC;
  localparam int unsigned VS0 = V_VISIBLE + V_FRONT;
  localparam int unsigned VS1 = VS0 + V_SYNC;

  localparam int unsigned XCW = $clog2(WHOLE_LINE);
  localparam int unsigned YCW = $clog2(WHOLE_FRAME);
  localparam int unsigned XW  = $clog2(H_VISIBLE);
  localparam int unsigned YW  = $clog2(V_VISIBLE);

  localparam logic [XCW-1:0] X_LAST = XCW'(WHOLE_LINE - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(WHOLE_FRAME - 1);
  localparam logic [XCW-1:0] HS0_C  = XCW'(HS0);
  localparam logic [XCW-1:0] HS1_C  = XCW'(HS1);
  localparam logic [YCW-1:0] VS0_C  = YCW'(VS0);
  localparam logic [YCW-1:0] VS1_C  = YCW'(VS1);
  localparam logic [XCW-1:0] HVIS_C = XCW'(H_VISIBLE);
  localparam logic [YCW-1:0] VVIS_C = YCW'(V_VISIBLE);

  typedef enum logic [1:0] {
    SEARCH,
    HLOCK,
    LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [XCW-1:0] x_q, x_d, x_n;
  logic [YCW-1:0] y_q, y_d, y_n;
  logic           hs_q, vs_q;
  logic           err_q, err_d;

  logic fall_h, rise_h, fall_v, rise_v;
  logic h_err, v_err;

  assign fall_h = hs_q & ~vga.hsync_i;
  assign rise_h = ~hs_q & vga.hsync_i;
  assign fall_v = vs_q & ~vga.vsync_i;
  assign rise_v = ~vs_q & vga.vsync_i;

  // x_n/y_n: coordinate of the sample currently on the inputs.
  always_comb begin
    x_n = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    y_n = y_q;
    if (x_q == X_LAST) begin
      y_n = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // Each sync edge must coincide exactly with its expected coordinate and vice versa.
  always_comb begin
    h_err = (fall_h != (x_n == HS0_C)) || (rise_h != (x_n == HS1_C));
    v_err = (fall_v != ((x_n == '0) && (y_n == VS0_C))) ||
            (rise_v != ((x_n == '0) && (y_n == VS1_C)));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        x_d = '0;
        y_d = '0;
        if (fall_h) begin
          x_d     = HS0_C;
          state_d = HLOCK;
        end
      end
      HLOCK: begin
        x_d = x_n;
        y_d = '0;
        if (fall_v) begin
          if (x_n == '0) begin
            y_d     = VS0_C;
            state_d = LOCKED;
          end else begin
            err_d = 1'b1;
          end
        end
        if (h_err) begin
          err_d = 1'b1;
        end
      end
      LOCKED: begin
        x_d   = x_n;
        y_d   = y_n;
        err_d = h_err | v_err;
      end
      default: begin
        state_d = SEARCH;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
    // The offending edge is consumed here, so reacquisition waits for a fresh fall_h.
    if (err_d) begin
      state_d = SEARCH;
      x_d     = '0;
      y_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEARCH;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= vga.hsync_i;
      vs_q    <= vga.vsync_i;
      err_q   <= err_d;
    end
  end

  logic locked;
  assign locked = (state_q == LOCKED);

  assign vga.locked_o      = locked;
  assign vga.visible_o     = locked && (x_q < HVIS_C) && (y_q < VVIS_C);
  assign vga.position_x_o  = locked ? x_q[XW-1:0] : '0;
  assign vga.position_y_o  = locked ? y_q[YW-1:0] : '0;
  assign vga.frame_start_o = locked && (x_q == '0) && (y_q == '0);
  assign vga.error_o       = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced timing so several frames fit in a short run.
// Directed fault scenarios mark their error sample by hand; a monitor compares every output cycle.
module tb_vga_sync_decoder;

  localparam int HV = 20, HF = 4, HSW = 6, HB = 5;
  localparam int VV = 10, VF = 3, VSW = 2, VB = 4;
  localparam int LINE  = HV + HF + HSW + HB;   // 35
  localparam int FRAME = VV + VF + VSW + VB;   // 19
  localparam int HS0 = HV + HF;                // 24
  localparam int HS1 = HS0 + HSW;              // 30
  localparam int VS0 = VV + VF;                // 13
  localparam int VS1 = VS0 + VSW;              // 15
  localparam int XW = $clog2(HV);              // 5
  localparam int YW = $clog2(VV);              // 4

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if #(.H_VISIBLE(HV), .V_VISIBLE(VV)) vif ();

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vif)
  );

  typedef struct {
    int unsigned   cyc;
    int            sid;
    int            gx;
    int            gy;
    logic          l;
    logic          v;
    logic          fs;
    logic          e;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
  } exp_t;

  exp_t q[$];
  string names[7] = '{"reset", "nominal", "early_hsync", "short_hsync",
                      "misaligned_vsync", "missing_hsync", "mid_reset"};

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Timing generator and scenario state
  int gx, gy, sid;
  bit h_force_en = 0, h_force_val = 0, v_force_en = 0, v_force_val = 0;
  bit prev_h = 0, prev_v = 0;
  bit exp_h = 0, exp_l = 0;

  // Monitor: compares whenever the scoreboard holds an entry due this cycle.
  always @(negedge clk) begin
    exp_t it;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      it = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s missed_sample gen=(%0d,%0d) got no compare, required cycle %0d",
               names[it.sid], it.gx, it.gy, it.cyc);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      it = q.pop_front();
      n_checks++;
      if ({vif.locked_o, vif.visible_o, vif.frame_start_o, vif.error_o,
           vif.position_x_o, vif.position_y_o} !==
          {it.l, it.v, it.fs, it.e, it.px, it.py}) begin
        n_fail++;
        $display("FAIL %s gen=(%0d,%0d) got locked=%b vis=%b fs=%b err=%b x=%0d y=%0d, required locked=%b vis=%b fs=%b err=%b x=%0d y=%0d",
                 names[it.sid], it.gx, it.gy,
                 vif.locked_o, vif.visible_o, vif.frame_start_o, vif.error_o,
                 vif.position_x_o, vif.position_y_o,
                 it.l, it.v, it.fs, it.e, it.px, it.py);
      end
    end
  end

  // Drive one generator sample; err marks a hand-identified timing violation at this sample.
  task automatic tick(input bit err);
    logic h, v;
    exp_t it;
    h = h_force_en ? h_force_val : !(gx >= HS0 && gx < HS1);
    v = v_force_en ? v_force_val : !(gy >= VS0 && gy < VS1);
    if (rst || err) begin
      exp_h = 0;
      exp_l = 0;
    end else if (!exp_h) begin
      if (prev_h && !h) exp_h = 1;
    end else if (!exp_l && prev_v && !v && gx == 0) begin
      exp_l = 1;
    end
    it.cyc = cyc + 1;
    it.sid = sid;
    it.gx  = gx;
    it.gy  = gy;
    it.l   = exp_l;
    it.v   = exp_l && gx < HV && gy < VV;
    it.fs  = exp_l && gx == 0 && gy == 0;
    it.e   = err && !rst;
    it.px  = exp_l ? gx[XW-1:0] : '0;
    it.py  = exp_l ? gy[YW-1:0] : '0;
    q.push_back(it);
    vif.hsync_i = h;
    vif.vsync_i = v;
    prev_h = rst ? 1'b0 : h;
    prev_v = rst ? 1'b0 : v;
    @(posedge clk);
    #1;
    if (gx == LINE - 1) begin
      gx = 0;
      gy = (gy == FRAME - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run_to(input int x, input int y);
    while (!(gx == x && gy == y)) tick(0);
  endtask

  task automatic wait_lock();
    int n = 0;
    while (!exp_l && n < 3 * LINE * FRAME) begin
      tick(0);
      n++;
    end
  endtask

  initial begin
    vif.hsync_i = 1'b1;
    vif.vsync_i = 1'b1;
    // Generator leaves reset at (HS1, VS1)
    gx = HS1 - 2;
    gy = VS1;
    sid = 0;
    rst = 1;
    tick(0);
    tick(0);
    rst = 0;

    sid = 1;
    wait_lock();
    repeat (3 * LINE * FRAME) tick(0);

    sid = 2;
    run_to(HS0 - 1, 3);
    h_force_en = 1; h_force_val = 0;
    tick(1);
    h_force_en = 0;
    wait_lock();

    sid = 3;
    run_to(HS1 - 1, 3);
    h_force_en = 1; h_force_val = 1;
    tick(1);
    h_force_en = 0;

    sid = 4;
    run_to(5, 5);
    v_force_en = 1; v_force_val = 0;
    tick(1);
    tick(0);
    tick(0);
    v_force_en = 0;
    wait_lock();

    sid = 5;
    run_to(0, 2);
    h_force_en = 1; h_force_val = 1;
    for (int i = 0; i < LINE; i++) tick(gx == HS0);
    h_force_en = 0;
    wait_lock();

    sid = 6;
    run_to(12, 6);
    rst = 1;
    tick(0);
    rst = 0;
    wait_lock();
    repeat (LINE * FRAME) tick(0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
